// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the hazard/stall controller: state encodings,
// write-back select code for loads, register address width and default slow-device wait.
package hazard_stall_ctrl_pkg;

    localparam int          REG_ADDR_BUS      = 4;
    localparam int          SLOW_WAIT_DEFAULT = 3;
    localparam logic [2:0]  WB_DATA_OP_MEM    = 3'd1;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2
    } stall_state_e;

endpackage

// File: rtl/hazard_stall_ctrl_perf_counter.sv
// Saturating 16-bit event counter for stall/flush statistics.
// Only compiled when STALL_PERF_CNT_EN is defined.
`ifdef STALL_PERF_CNT_EN
module stall_perf_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] count
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule
`endif

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use, branch flush, shared-bus conflict and
// slow-device freeze. Optional perf counters under macro STALL_PERF_CNT_EN.
//
// state         | meaning
// RUN           | normal flow, all hazards evaluated
// LOAD_STALL    | bubble inserted for a load-use; behaves like RUN
// MEM_WAIT      | slow-device freeze; wait counter != 0 freezes, == 0 is the release cycle
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int SLOW_WAIT = SLOW_WAIT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REG_ADDR_BUS-1:0] id_reg1_addr,
    input  logic [REG_ADDR_BUS-1:0] id_reg2_addr,
    input  logic                    id_reg1_read,
    input  logic                    id_reg2_read,
    input  logic [REG_ADDR_BUS-1:0] ex_wb_addr,
    input  logic                    ex_reg_write,
    input  logic [2:0]              ex_wb_data_op,
    input  logic                    mem_access_req,
    input  logic                    mem_slow,
    input  logic                    ex_branch_taken,
    output logic                    pc_hold,
    output logic                    if_id_hold,
    output logic                    if_id_flush,
    output logic                    id_ex_hold,
    output logic                    id_ex_flush,
    output logic                    ex_mem_hold,
    output logic                    mem_wb_flush,
    output logic [1:0]              stall_state,
    output logic [15:0]             stall_cycles,
    output logic [15:0]             flush_count
);

    localparam logic [3:0] WAIT_LOAD = 4'(SLOW_WAIT - 1);

    stall_state_e state_q, state_d;
    logic [3:0]   wait_cnt_q, wait_cnt_d;

    logic load_use, slow, conflict, frozen, allow_slow;
    logic pc_hold_c, if_id_hold_c, if_id_flush_c, id_ex_hold_c;
    logic id_ex_flush_c, ex_mem_hold_c, mem_wb_flush_c;

    assign load_use = ex_reg_write && (ex_wb_data_op == WB_DATA_OP_MEM) &&
                      ((id_reg1_read && (id_reg1_addr == ex_wb_addr)) ||
                       (id_reg2_read && (id_reg2_addr == ex_wb_addr)));
    assign slow       = mem_access_req && mem_slow;
    assign conflict   = mem_access_req && !mem_slow;
    assign frozen     = (state_q == ST_MEM_WAIT) && (wait_cnt_q != 4'd0);
    assign allow_slow = (state_q != ST_MEM_WAIT);

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        pc_hold_c      = 1'b0;
        if_id_hold_c   = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_hold_c   = 1'b0;
        id_ex_flush_c  = 1'b0;
        ex_mem_hold_c  = 1'b0;
        mem_wb_flush_c = 1'b0;

        if (frozen || (allow_slow && slow)) begin
            pc_hold_c      = 1'b1;
            if_id_hold_c   = 1'b1;
            id_ex_hold_c   = 1'b1;
            ex_mem_hold_c  = 1'b1;
            mem_wb_flush_c = 1'b1;
            if (frozen) begin
                wait_cnt_d = wait_cnt_q - 4'd1;
            end else begin
                wait_cnt_d = WAIT_LOAD;
                state_d    = ST_MEM_WAIT;
            end
        end else if (ex_branch_taken) begin
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
            state_d       = ST_RUN;
        end else begin
            state_d = ST_RUN;
            // a bus conflict and a load-use can stack in the same cycle
            if (conflict) begin
                pc_hold_c     = 1'b1;
                if_id_flush_c = 1'b1;
            end
            if (load_use) begin
                pc_hold_c     = 1'b1;
                if_id_hold_c  = 1'b1;
                id_ex_flush_c = 1'b1;
                state_d       = ST_LOAD_STALL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // gate with reset so outputs drop immediately, without waiting for a clock
    assign pc_hold      = pc_hold_c      & rst;
    assign if_id_hold   = if_id_hold_c   & rst;
    assign if_id_flush  = if_id_flush_c  & rst;
    assign id_ex_hold   = id_ex_hold_c   & rst;
    assign id_ex_flush  = id_ex_flush_c  & rst;
    assign ex_mem_hold  = ex_mem_hold_c  & rst;
    assign mem_wb_flush = mem_wb_flush_c & rst;
    assign stall_state  = state_q;

`ifdef STALL_PERF_CNT_EN
    // a branch flush is the only id_ex_flush without pc_hold
    stall_perf_counter u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (pc_hold),
        .count (stall_cycles)
    );

    stall_perf_counter u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (id_ex_flush & ~pc_hold),
        .count (flush_count)
    );
`else
    assign stall_cycles = 16'd0;
    assign flush_count  = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl; counter expectations follow STALL_PERF_CNT_EN.
module tb_hazard_stall_ctrl;

`ifdef STALL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // output vector bit order: pc, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_hold, mem_wb_flush
    localparam logic [6:0] O_NONE   = 7'h00;
    localparam logic [6:0] O_LU     = 7'h64;
    localparam logic [6:0] O_BR     = 7'h14;
    localparam logic [6:0] O_FRZ    = 7'h6B;
    localparam logic [6:0] O_CF     = 7'h50;
    localparam logic [6:0] O_CF_LU  = 7'h74;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  id_reg1_addr, id_reg2_addr, ex_wb_addr;
    logic        id_reg1_read, id_reg2_read, ex_reg_write;
    logic [2:0]  ex_wb_data_op;
    logic        mem_access_req, mem_slow, ex_branch_taken;
    logic        pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_hold, mem_wb_flush;
    logic [1:0]  stall_state;
    logic [15:0] stall_cycles, flush_count;
    logic [6:0]  outs;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    always #5 clk = ~clk;

    assign outs = {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_hold, mem_wb_flush};

    hazard_stall_ctrl #(.SLOW_WAIT(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_reg1_addr    (id_reg1_addr),
        .id_reg2_addr    (id_reg2_addr),
        .id_reg1_read    (id_reg1_read),
        .id_reg2_read    (id_reg2_read),
        .ex_wb_addr      (ex_wb_addr),
        .ex_reg_write    (ex_reg_write),
        .ex_wb_data_op   (ex_wb_data_op),
        .mem_access_req  (mem_access_req),
        .mem_slow        (mem_slow),
        .ex_branch_taken (ex_branch_taken),
        .pc_hold         (pc_hold),
        .if_id_hold      (if_id_hold),
        .if_id_flush     (if_id_flush),
        .id_ex_hold      (id_ex_hold),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_hold     (ex_mem_hold),
        .mem_wb_flush    (mem_wb_flush),
        .stall_state     (stall_state),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        id_reg1_addr = 4'd0; id_reg2_addr = 4'd0; ex_wb_addr = 4'd0;
        id_reg1_read = 1'b0; id_reg2_read = 1'b0; ex_reg_write = 1'b0;
        ex_wb_data_op = 3'd0; mem_access_req = 1'b0; mem_slow = 1'b0; ex_branch_taken = 1'b0;
    endtask

    task automatic set_load_use();
        ex_reg_write = 1'b1; ex_wb_data_op = 3'd1; ex_wb_addr = 4'd3;
        id_reg1_addr = 4'd3; id_reg1_read = 1'b1;
    endtask

    // called at posedge+2 with inputs applied; checks mid-cycle, returns at next posedge+2
    task automatic cyc(input string tag, input logic [6:0] exp_o, input logic [1:0] exp_st);
        #3;
        check_val({tag, "_outs"}, {25'd0, outs}, {25'd0, exp_o});
        check_val({tag, "_state"}, {30'd0, stall_state}, {30'd0, exp_st});
        if (exp_o[6]) exp_stall++;
        if (exp_o[2] && !exp_o[6]) exp_flush++;
        @(posedge clk);
        #2;
    endtask

    task automatic check_perf(input string tag);
        check_val({tag, "_stall_cycles"}, {16'd0, stall_cycles}, PERF ? 32'(exp_stall) : 32'd0);
        check_val({tag, "_flush_count"}, {16'd0, flush_count}, PERF ? 32'(exp_flush) : 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        clear_inputs();
        set_load_use();
        #3;
        check_val("rst_outs", {25'd0, outs}, 32'd0);
        check_val("rst_state", {30'd0, stall_state}, 32'd0);
        check_perf("rst");
        @(posedge clk);
        #2;
        check_val("rst_clk_outs", {25'd0, outs}, 32'd0);
        clear_inputs();
        rst = 1'b1;

        cyc("idle", O_NONE, 2'd0);

        set_load_use();
        cyc("lu_hit", O_LU, 2'd0);
        clear_inputs();
        cyc("lu_bubble", O_NONE, 2'd1);
        cyc("lu_back", O_NONE, 2'd0);

        set_load_use();
        id_reg1_read = 1'b0;
        cyc("lu_miss_noread", O_NONE, 2'd0);
        id_reg2_read = 1'b1;
        id_reg2_addr = 4'd4;
        cyc("lu_miss_addr", O_NONE, 2'd0);
        id_reg2_addr = 4'd3;
        cyc("lu_hit_reg2", O_LU, 2'd0);
        clear_inputs();
        set_load_use();
        ex_wb_data_op = 3'd0;
        cyc("lu_alu_op", O_NONE, 2'd1);

        set_load_use();
        ex_branch_taken = 1'b1;
        cyc("br_prio", O_BR, 2'd0);
        clear_inputs();
        cyc("br_after", O_NONE, 2'd0);
        check_perf("br");

        mem_access_req = 1'b1;
        cyc("conflict", O_CF, 2'd0);
        set_load_use();
        cyc("conflict_lu", O_CF_LU, 2'd0);
        clear_inputs();
        ex_branch_taken = 1'b1;
        cyc("ls_branch", O_BR, 2'd1);
        clear_inputs();
        cyc("ls_back", O_NONE, 2'd0);

        mem_access_req = 1'b1; mem_slow = 1'b1; ex_branch_taken = 1'b1;
        cyc("slow_0", O_FRZ, 2'd0);
        cyc("slow_1", O_FRZ, 2'd2);
        cyc("slow_2", O_FRZ, 2'd2);
        cyc("slow_release", O_BR, 2'd2);
        clear_inputs();
        check_perf("slow");
        cyc("slow_done", O_NONE, 2'd0);

        set_load_use();
        cyc("w_lu", O_LU, 2'd0);
        clear_inputs();
        mem_access_req = 1'b1; mem_slow = 1'b1;
        cyc("w_slow_ls", O_FRZ, 2'd1);
        cyc("w_wait2", O_FRZ, 2'd2);
        rst = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
        #1;
        check_val("rstwait_outs", {25'd0, outs}, 32'd0);
        check_val("rstwait_state", {30'd0, stall_state}, 32'd0);
        check_perf("rstwait");
        clear_inputs();
        ex_branch_taken = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        cyc("post_rst_branch", O_BR, 2'd0);
        clear_inputs();
        check_perf("post_rst");

`ifdef STALL_PERF_CNT_EN
        mem_access_req = 1'b1;
        #3;
        check_val("sat_conflict_outs", {25'd0, outs}, {25'd0, O_CF});
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
        end
        #2;
        check_val("sat_value", {16'd0, stall_cycles}, 32'h0000FFFF);
        repeat (3) @(posedge clk);
        #2;
        check_val("sat_nowrap", {16'd0, stall_cycles}, 32'h0000FFFF);
        check_val("sat_flush", {16'd0, flush_count}, 32'd1);
        clear_inputs();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL have parameter: SLOW_WAIT, 3, number of whole-pipeline freeze cycles per slow-device access (legal 1..15).
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: id_reg1_addr, id_reg2_addr  in  4  ID source register addresses.
REQ-005 SHALL have ports: id_reg1_read, id_reg2_read  in  1  ID instruction actually reads that source.
REQ-006 SHALL have ports: ex_wb_addr  in  4 and ex_reg_write  in  1  EX destination register and write intent.
REQ-007 SHALL have port: ex_wb_data_op  in  3  EX write-back source select; value WB_DATA_OP_MEM marks a load.
REQ-008 SHALL have ports: mem_access_req  in  1 and mem_slow  in  1  MEM-stage data access present; target is a slow device.
REQ-009 SHALL have port: ex_branch_taken  in  1  EX branch/jump resolved taken.
REQ-010 SHALL have outputs, 1 bit each: pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_hold, mem_wb_flush.
REQ-011 SHALL have outputs: stall_state  out  2  current FSM state; stall_cycles, flush_count  out  16  performance counters.

Function
REQ-012 SHALL implement FSM states: RUN=0, LOAD_STALL=1, MEM_WAIT=2, plus a 4-bit wait counter.
REQ-013 SHALL define load_use = ex_reg_write && ex_wb_data_op==WB_DATA_OP_MEM && ((id_reg1_read && id_reg1_addr==ex_wb_addr) || (id_reg2_read && id_reg2_addr==ex_wb_addr)).
REQ-014 SHALL evaluate these conditions in RUN and LOAD_STALL, highest priority first:
  - slow: mem_access_req && mem_slow
  - branch: ex_branch_taken
  - conflict: mem_access_req && !mem_slow
  - load_use
REQ-015 SHALL, on slow: assert pc_hold, if_id_hold, id_ex_hold, ex_mem_hold and mem_wb_flush; load the counter with SLOW_WAIT-1; next state MEM_WAIT.
REQ-016 SHALL, on branch: assert if_id_flush and id_ex_flush, keep pc_hold=0, ignore load_use; next state RUN.
REQ-017 SHALL, on conflict (instruction/data bus shared): assert pc_hold and if_id_flush for that cycle only; load_use is also applied if present.
REQ-018 SHALL, on load_use: assert pc_hold, if_id_hold and id_ex_flush; next state LOAD_STALL.
REQ-019 SHALL, in LOAD_STALL, produce outputs as in RUN; next state RUN unless slow or load_use re-triggers.
REQ-020 SHALL, in MEM_WAIT with counter≠0, assert the full freeze set of REQ-015, force all flush outputs except mem_wb_flush to 0, and decrement the counter.
REQ-021 SHALL, in MEM_WAIT with counter==0 (release cycle), drive no freeze, evaluate branch/conflict/load_use as in RUN, and not re-trigger slow; next state RUN, or LOAD_STALL on load_use.
REQ-022 SHALL freeze the pipeline for exactly SLOW_WAIT cycles per slow access.
REQ-023 SHALL produce all hold/flush outputs combinationally from the current state and inputs (zero latency).

Reset
REQ-024 SHALL, while rst=0, force state to RUN, counter to 0, stall_cycles and flush_count to 0, and all hold/flush outputs to 0, independent of clk.
REQ-025 SHALL, when reset is asserted mid-MEM_WAIT, abandon the wait; the first cycle after release is evaluated in RUN.

Configuration
REQ-026 SHALL use macro STALL_PERF_CNT_EN.
  - Defined: stall_cycles increments each cycle pc_hold=1; flush_count increments each cycle id_ex_flush=1 due to branch; both saturate at 0xFFFF.
  - Undefined: both ports are tied to 0 and no counter registers exist.

Structure
REQ-027 SHALL take the following from the shared define file: state encodings, WB_DATA_OP_MEM, the REG_ADDR_BUS width (4) and the default SLOW_WAIT.
REQ-028 SHALL place the saturating 16-bit counter in sub-module stall_perf_counter, instantiated twice, only under STALL_PERF_CNT_EN.

Verification
REQ-029 SHALL cover load-use hit:
  - Stimulus: ex_wb_data_op=MEM, ex_reg_write=1, ex_wb_addr=3, id_reg1_addr=3, id_reg1_read=1.
  - Response, cycle N: pc_hold=if_id_hold=id_ex_flush=1, next state=1.
  - Response, cycle N+1 (bubble in EX): all outputs 0, state returns to 0.
REQ-030 SHALL cover load-use miss:
  - Stimulus: as REQ-029 with id_reg1_read=0, or with id_reg2_addr=4 and ex_wb_addr=3.
  - Response: no hold, no flush, state stays 0.
REQ-031 SHALL cover branch priority:
  - Stimulus: ex_branch_taken=1 together with the load-use of REQ-029.
  - Response: if_id_flush=id_ex_flush=1, pc_hold=0, state stays 0, flush_count +1.
REQ-032 SHALL cover slow access:
  - Stimulus: SLOW_WAIT=3, mem_access_req=1, mem_slow=1, ex_branch_taken=1.
  - Response: full freeze for 3 cycles with flush outputs held 0 except mem_wb_flush.
  - Release cycle: id_ex_flush=1 for the pending branch; stall_cycles +3.
REQ-033 SHALL cover reset in wait:
  - Stimulus: rst driven 0 asynchronously in MEM_WAIT with counter=1.
  - Response: outputs 0 and stall_state=0 immediately; counters 0.
REQ-034 SHALL cover counter saturation:
  - Stimulus: with STALL_PERF_CNT_EN, hold conflict for 65540 cycles.
  - Response: stall_cycles=0xFFFF and does not wrap.
